cgra0_rd_arbiter: RTL and testbench
===================================

CGRA0_RD_ARBITER -- requirements
Module: cgra0_rd_arbiter

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- NREQ, 9, number of requesters (index 0 = configuration controller, 1..8 = input FIFO feeders).
- DW, 512, memory read data width in bits.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1: single clock; all logic is on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- req_en, in, NREQ: per-requester enable; bit 0 is tied high by the integrator, bits 1..8 come from read_fifo_mask.
- req, in, NREQ: level request; held high by the requester until its data is returned.
- available_read, in, 1: memory read channel can accept a request.
- req_rd_data, out, 1: one-cycle read request pulse to memory.
- rd_data, in, DW: memory read data.
- rd_data_valid, in, 1: rd_data is valid this cycle.
- rd_data_out, out, DW: registered data broadcast to all requesters.
- rd_data_valid_out, out, NREQ: one-hot, one-cycle valid to the owning requester.
- grant_id, out, 4: index of the current or last owner.
- busy, out, 1: high in every state except IDLE.
- timeout_err, out, 1: sticky timeout flag (see Configuration).

Function
REQ-003 The FSM SHALL have exactly three states, IDLE, WAIT and RESP, and SHALL use only the following transitions.
REQ-004 IDLE → WAIT when available_read=1 and (req & req_en) ≠ 0; on that edge the block SHALL:
- register the winner into grant_id;
- drive req_rd_data=1 for exactly the following cycle.
REQ-005 Winner selection SHALL be round-robin: the first set bit of (req & req_en) searching upward from last_grant+1, wrapping from NREQ-1 to 0.
REQ-006 In IDLE, if available_read=0 or no enabled request is present, the block SHALL stay in IDLE with req_rd_data=0.
REQ-007 WAIT → RESP on the edge where rd_data_valid=1; on that edge the block SHALL:
- capture rd_data_out <= rd_data;
- set rd_data_valid_out[grant_id] <= 1;
- set last_grant <= grant_id.
REQ-008 RESP → IDLE unconditionally after one cycle; on that edge the block SHALL clear rd_data_valid_out to 0.
REQ-009 A requester SHALL deassert req on the edge where it samples its rd_data_valid_out high, so that the first IDLE evaluation never sees a stale request.
REQ-010 Latency SHALL be fixed:
- arbitration edge to req_rd_data pulse: 1 cycle;
- rd_data_valid to rd_data_valid_out: 1 cycle;
- at most one read SHALL be outstanding at any time.
REQ-011 rd_data_valid while in IDLE or RESP SHALL be ignored: no output change and no state change.
REQ-012 Changes to req_en or req during WAIT or RESP SHALL NOT affect the current owner; they take effect only at the next IDLE evaluation.
REQ-013 rd_data_out SHALL hold its last captured value whenever rd_data_valid_out is all zero.
REQ-014 If only one enabled requester is active, it SHALL be granted on every IDLE evaluation with no idle bubble beyond the RESP cycle.

Reset
REQ-015 With rst=1 at a clock edge, the block SHALL set the following values:
- state = IDLE;
- req_rd_data = 0, rd_data_valid_out = 0, rd_data_out = 0;
- grant_id = 0, busy = 0, timeout_err = 0;
- last_grant = NREQ-1, so requester 0 has first priority after reset.
REQ-016 A reset asserted during WAIT or RESP SHALL abandon the transaction; a late rd_data_valid arriving afterwards SHALL be ignored per REQ-011.
REQ-017 Initial-block values SHALL equal the reset values.

Configuration
REQ-018 Macro CGRA0_RD_ARB_TIMEOUT_EN SHALL control a read timeout.
- Defined: a 10-bit counter SHALL clear on entry to WAIT and increment each WAIT cycle. When it reaches 1023 with no rd_data_valid, the FSM SHALL go to IDLE, no rd_data_valid_out SHALL be issued, and timeout_err SHALL be set to 1 until rst.
- Undefined: WAIT SHALL persist indefinitely, no counter SHALL be present, and timeout_err SHALL be constant 0.

Verification
REQ-019 Single requester: req=9'h001, available_read=1, memory returns data 3 cycles after the pulse → one req_rd_data pulse; rd_data_valid_out=9'h001 for 1 cycle, 1 cycle after rd_data_valid, with matching data.
REQ-020 Round-robin fairness: req=9'h1FF held, req_en=9'h1FF, each requester drops req after one service → grant order 0,1,...,8, each exactly once.
REQ-021 Masking: req=9'h006, req_en=9'h003 → only requester 1 is granted; requester 2 is never granted until req_en[2]=1.
REQ-022 Back-pressure: available_read=0 for 20 cycles with req=9'h001 → req_rd_data stays 0 and busy=0; grant occurs on the first edge with available_read=1.
REQ-023 Reset in WAIT, then spurious rd_data_valid 2 cycles after reset release → state stays IDLE and rd_data_valid_out stays 0.
REQ-024 With CGRA0_RD_ARB_TIMEOUT_EN defined, no rd_data_valid for 1023 WAIT cycles → timeout_err=1, FSM returns to IDLE, and the next request is granted normally.

Source files
------------

// File: rtl/cgra0_rd_arbiter.sv
// Round-robin read arbiter: one memory read outstanding at a time, data broadcast with one-hot valid.
// Optional read timeout is compiled in with `define CGRA0_RD_ARB_TIMEOUT_EN.
module cgra0_rd_arbiter #(
    parameter int NREQ = 9,
    parameter int DW   = 512
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_en,
    input  logic [NREQ-1:0] req,
    input  logic            available_read,
    output logic            req_rd_data,
    input  logic [DW-1:0]   rd_data,
    input  logic            rd_data_valid,
    output logic [DW-1:0]   rd_data_out,
    output logic [NREQ-1:0] rd_data_valid_out,
    output logic [3:0]      grant_id,
    output logic            busy,
    output logic            timeout_err,
    output logic [1:0]      dbg_state
);

    // Handshake: req is a level held until the owner sees its rd_data_valid_out bit;
    // req_rd_data is a one-cycle pulse issued only when available_read was high at arbitration.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_last_grant;
    logic [3:0]        r_grant_id;
    logic [3:0]        w_winner;
    logic              w_any;
    logic              w_arb;
    logic              w_timeout;
    logic              r_req_rd_data;
    logic [DW-1:0]     r_rd_data;
    logic [NREQ-1:0]   r_valid_out;
    logic [NREQ-1:0]   w_active;
    logic [NREQ-1:0]   w_one;

    assign w_active = req & req_en;
    assign w_one    = {{(NREQ-1){1'b0}}, 1'b1};

    // Two passes: indices above last_grant first, then wrap to the low indices.
    always_comb begin
        w_any    = 1'b0;
        w_winner = 4'd0;
        for (int j = 0; j < NREQ; j++) begin
            if (!w_any && w_active[j] && (j > int'(r_last_grant))) begin
                w_any    = 1'b1;
                w_winner = 4'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!w_any && w_active[j] && (j <= int'(r_last_grant))) begin
                w_any    = 1'b1;
                w_winner = 4'(j);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        w_arb  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (available_read && w_any) begin
                    w_next = S_WAIT;
                    w_arb  = 1'b1;
                end
            end
            S_WAIT: begin
                if (rd_data_valid) begin
                    w_next = S_RESP;
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_rd_data <= 1'b0;
            r_grant_id    <= 4'd0;
            r_last_grant  <= 4'(NREQ - 1);
            r_rd_data     <= '0;
            r_valid_out   <= '0;
        end else begin
            r_req_rd_data <= w_arb;
            if (w_arb) begin
                r_grant_id <= w_winner;
            end
            // Valid is only ever set on the WAIT->RESP edge, so it self-clears after RESP.
            if (r_state == S_WAIT && rd_data_valid) begin
                r_rd_data    <= rd_data;
                r_valid_out  <= w_one << r_grant_id;
                r_last_grant <= r_grant_id;
            end else begin
                r_valid_out  <= '0;
            end
        end
    end

`ifdef CGRA0_RD_ARB_TIMEOUT_EN
    logic [9:0] r_timer;
    logic       r_timeout_err;

    assign w_timeout = (r_timer == 10'h3FF);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer       <= 10'd0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_arb) begin
                r_timer <= 10'd0;
            end else if (r_state == S_WAIT && !rd_data_valid) begin
                r_timer <= r_timer + 10'd1;
                if (w_timeout) begin
                    r_timeout_err <= 1'b1;
                end
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign req_rd_data       = r_req_rd_data;
    assign rd_data_out       = r_rd_data;
    assign rd_data_valid_out = r_valid_out;
    assign grant_id          = r_grant_id;
    assign busy              = (r_state != S_IDLE);
    assign dbg_state         = r_state;

endmodule

// File: tb/tb_cgra0_rd_arbiter.sv
// Directed bench for cgra0_rd_arbiter: expected owners and data are queued when stimulus is driven
// and popped when the arbiter grants or returns data.
module tb_cgra0_rd_arbiter;
    localparam int NREQ = 9;
    localparam int DW   = 512;

    logic            clk;
    logic            rst;
    logic [NREQ-1:0] req_en;
    logic [NREQ-1:0] req;
    logic            available_read;
    logic            req_rd_data;
    logic [DW-1:0]   rd_data;
    logic            rd_data_valid;
    logic [DW-1:0]   rd_data_out;
    logic [NREQ-1:0] rd_data_valid_out;
    logic [3:0]      grant_id;
    logic            busy;
    logic            timeout_err;
    logic [1:0]      dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] exp_q[$];
    logic [3:0]    id_q[$];
    logic [3:0]    exp_owner;
    int            cyc;

    cgra0_rd_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .clk               (clk),
        .rst               (rst),
        .req_en            (req_en),
        .req               (req),
        .available_read    (available_read),
        .req_rd_data       (req_rd_data),
        .rd_data           (rd_data),
        .rd_data_valid     (rd_data_valid),
        .rd_data_out       (rd_data_out),
        .rd_data_valid_out (rd_data_valid_out),
        .grant_id          (grant_id),
        .busy              (busy),
        .timeout_err       (timeout_err),
        .dbg_state         (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        req_en = '1;
        available_read = 1'b1;
        rd_data_valid = 1'b0;
        rd_data = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Waits for the read pulse, checks the owner against the queue head, then checks pulse width.
    task automatic wait_grant(output int n);
        n = 0;
        while (!req_rd_data && n < 40) begin
            tick();
            n++;
        end
        chk("pulse_seen", req_rd_data, 1);
        if (id_q.size() == 0) begin
            chk("id_q_nonempty", 0, 1);
            exp_owner = 4'd0;
        end else begin
            exp_owner = id_q.pop_front();
        end
        chk("grant_id", grant_id, exp_owner);
        chk("busy_wait", busy, 1);
        tick();
        chk("pulse_width", req_rd_data, 0);
    endtask

    // Memory returns one beat; optionally keeps valid high through RESP to show it is ignored.
    task automatic respond(input logic drop, input logic hold2);
        logic [DW-1:0]   d;
        logic [NREQ-1:0] oh;
        for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom();
        exp_q.push_back(d);
        rd_data = d;
        rd_data_valid = 1'b1;
        tick();
        oh = '0;
        oh[exp_owner] = 1'b1;
        chk("valid_out", rd_data_valid_out, oh);
        chk("rd_data_out", rd_data_out, exp_q.pop_front());
        if (hold2) rd_data = ~d;
        else rd_data_valid = 1'b0;
        if (drop) req[exp_owner] = 1'b0;
        tick();
        rd_data_valid = 1'b0;
        chk("valid_clear", rd_data_valid_out, 0);
        chk("data_hold", rd_data_out, d);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        req_en = '1;
        available_read = 1'b1;
        rd_data_valid = 1'b0;
        rd_data = '0;
        exp_owner = 4'd0;
        repeat (3) tick();
        chk("rst_state", dbg_state, 0);
        chk("rst_pulse", req_rd_data, 0);
        chk("rst_valid_out", rd_data_valid_out, 0);
        chk("rst_data", rd_data_out, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout_err, 0);
        rst = 1'b0;

        // Single requester, valid held into RESP, then spurious valid in IDLE.
        id_q.push_back(4'd0);
        req = 9'h001;
        wait_grant(cyc);
        chk("single_lat", cyc, 1);
        repeat (2) tick();
        respond(1'b1, 1'b1);
        rd_data = '1;
        rd_data_valid = 1'b1;
        tick();
        rd_data_valid = 1'b0;
        chk("idle_valid_ignored", rd_data_valid_out, 0);
        chk("idle_state", dbg_state, 0);
        chk("idle_no_pulse", req_rd_data, 0);
        tick();
        chk("idle_no_pulse2", req_rd_data, 0);

        // Round-robin fairness from reset: 0..8 in order, no bubble between owners.
        do_reset();
        for (int k = 0; k < NREQ; k++) id_q.push_back(4'(k));
        req = 9'h1FF;
        for (int k = 0; k < NREQ; k++) begin
            wait_grant(cyc);
            chk("rr_lat", cyc, 1);
            respond(1'b1, 1'b0);
        end
        chk("rr_drained", id_q.size(), 0);
        tick();
        chk("rr_quiet", busy, 0);

        // Masking: requester 2 waits until its enable arrives.
        do_reset();
        req_en = 9'h003;
        req = 9'h006;
        id_q.push_back(4'd1);
        wait_grant(cyc);
        respond(1'b1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("mask_no_pulse", req_rd_data, 0);
            chk("mask_no_busy", busy, 0);
        end
        req_en = 9'h007;
        id_q.push_back(4'd2);
        wait_grant(cyc);
        chk("mask_lat", cyc, 1);
        respond(1'b1, 1'b0);

        // Back-pressure: nothing issues until available_read returns.
        do_reset();
        available_read = 1'b0;
        req = 9'h001;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("bp_no_pulse", req_rd_data, 0);
            chk("bp_no_busy", busy, 0);
        end
        available_read = 1'b1;
        id_q.push_back(4'd0);
        wait_grant(cyc);
        chk("bp_lat", cyc, 1);
        respond(1'b1, 1'b0);

        // Continuous single requester; request/enable changes in WAIT apply only at next IDLE.
        do_reset();
        req = 9'h001;
        id_q.push_back(4'd0);
        wait_grant(cyc);
        chk("cont_lat0", cyc, 1);
        tick();
        respond(1'b0, 1'b0);
        id_q.push_back(4'd0);
        wait_grant(cyc);
        chk("cont_no_bubble", cyc, 1);
        req = 9'h003;
        req_en = 9'h1FE;
        tick();
        chk("owner_stable", grant_id, 0);
        respond(1'b0, 1'b0);
        id_q.push_back(4'd1);
        wait_grant(cyc);
        chk("late_change_lat", cyc, 1);
        respond(1'b1, 1'b0);
        req = '0;

        // Reset during WAIT, then a late valid two cycles after release.
        do_reset();
        req = 9'h001;
        id_q.push_back(4'd0);
        wait_grant(cyc);
        chk("pre_rst_state", dbg_state, 1);
        rst = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
        chk("wrst_state", dbg_state, 0);
        chk("wrst_busy", busy, 0);
        chk("wrst_grant", grant_id, 0);
        tick();
        tick();
        rd_data = '1;
        rd_data_valid = 1'b1;
        tick();
        rd_data_valid = 1'b0;
        chk("late_valid_state", dbg_state, 0);
        chk("late_valid_out", rd_data_valid_out, 0);
        chk("late_valid_data", rd_data_out, 0);
        tick();
        chk("late_valid_state2", dbg_state, 0);

`ifdef CGRA0_RD_ARB_TIMEOUT_EN
        do_reset();
        req = 9'h001;
        id_q.push_back(4'd0);
        wait_grant(cyc);
        cyc = 0;
        while (busy && cyc < 1100) begin
            chk("to_no_valid", rd_data_valid_out, 0);
            tick();
            cyc++;
        end
        chk("to_idle", busy, 0);
        chk("to_err", timeout_err, 1);
        chk("to_valid", rd_data_valid_out, 0);
        id_q.push_back(4'd0);
        wait_grant(cyc);
        chk("to_regrant_lat", cyc, 1);
        respond(1'b1, 1'b0);
        chk("to_err_sticky", timeout_err, 1);
`else
        chk("no_timeout_err", timeout_err, 0);
`endif

        chk("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
